// File: rtl/lfsr_uart_stream.sv
`timescale 1ns/1ps
// rtl/lfsr_uart_stream.sv - Galois LFSR byte source driving a UART transmitter
// Optional even-parity bit per frame when LFSR_UART_PARITY_EN is defined.
module lfsr_uart_stream #(
   parameter int                LFSR_W  = 32,
   parameter logic [LFSR_W-1:0] TAPS    = 32'h80200003,
   parameter logic [LFSR_W-1:0] SEED    = 32'h00000001,
   parameter int                CLK_DIV = 104,
   parameter int                BURST_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               stop,
   input  logic [BURST_W-1:0] burst_len,
   input  logic               reseed,
   input  logic [LFSR_W-1:0]  seed_val,
   output logic               tx,
   output logic               busy,
   output logic [7:0]         byte_out,
   output logic               byte_stb,
   output logic [BURST_W-1:0] sent_cnt,
   output logic               done
);

   localparam int                BAUD_W    = $clog2(CLK_DIV);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      START  = 3'd2,
      DATA   = 3'd3,
`ifdef LFSR_UART_PARITY_EN
      PARITY = 3'd4,
`endif
      STOP   = 3'd5
   } state_t;

   state_t             state, next_state;
   logic [LFSR_W-1:0]  lfsr;
   logic [BURST_W-1:0] burst_q;
   logic [BAUD_W-1:0]  baud_cnt;
   logic [2:0]         bit_cnt;
   logic               stop_q;
   logic               bit_end;
   logic               finish;

   assign busy    = (state != IDLE);
   assign bit_end = (baud_cnt == BAUD_LAST);
   // A stop arriving in the very last stop-bit cycle still ends the run.
   assign finish  = stop_q || stop || ((burst_q != '0) && (sent_cnt == burst_q));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      tx         = 1'b1;
      case (state)
         IDLE: begin
            if (start) next_state = LOAD;
         end
         LOAD: begin
            next_state = START;
         end
         START: begin
            tx = 1'b0;
            if (bit_end) next_state = DATA;
         end
         DATA: begin
            tx = byte_out[bit_cnt];
            if (bit_end && (bit_cnt == 3'd7)) begin
`ifdef LFSR_UART_PARITY_EN
               next_state = PARITY;
`else
               next_state = STOP;
`endif
            end
         end
`ifdef LFSR_UART_PARITY_EN
         PARITY: begin
            tx = ^byte_out;
            if (bit_end) next_state = STOP;
         end
`endif
         STOP: begin
            if (bit_end) next_state = finish ? IDLE : LOAD;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr     <= SEED;
         burst_q  <= '0;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         stop_q   <= 1'b0;
         byte_out <= '0;
         byte_stb <= 1'b0;
         sent_cnt <= '0;
         done     <= 1'b0;
      end else begin
         byte_stb <= 1'b0;
         done     <= (state == STOP) && bit_end && finish;

         if (state == IDLE || state == LOAD || bit_end) begin
            baud_cnt <= '0;
         end else begin
            baud_cnt <= baud_cnt + 1'b1;
         end

         if (state != DATA) begin
            bit_cnt <= '0;
         end else if (bit_end) begin
            bit_cnt <= bit_cnt + 1'b1;
         end

         if (next_state == IDLE) begin
            stop_q <= 1'b0;
         end else if (stop && state != IDLE) begin
            stop_q <= 1'b1;
         end

         if (state == IDLE) begin
            if (start) begin
               burst_q  <= burst_len;
               sent_cnt <= '0;
            end else if (reseed) begin
               lfsr <= (seed_val == '0) ? SEED : seed_val;
            end
         end

         // Byte and strobe are registered together on entry to LOAD.
         if (next_state == LOAD) begin
            byte_out <= lfsr[7:0];
            byte_stb <= 1'b1;
         end

         if (state == LOAD) begin
            lfsr     <= (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);
            sent_cnt <= sent_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_lfsr_uart_stream.sv
`timescale 1ns/1ps
// tb/tb_lfsr_uart_stream.sv - bench for lfsr_uart_stream against a frame-level model
module tb_lfsr_uart_stream;

   localparam int         CD = 4;
   localparam logic [7:0] TP = 8'hB8;
   localparam logic [7:0] SD = 8'h01;
`ifdef LFSR_UART_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int P = NB * CD + 1;

   logic       clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0, reseed = 1'b0;
   logic [7:0] burst_len = 8'd0, seed_val = 8'd0;
   logic       tx, busy, byte_stb, done;
   logic [7:0] byte_out, sent_cnt;

   lfsr_uart_stream #(
      .LFSR_W(8), .TAPS(TP), .SEED(SD), .CLK_DIV(CD), .BURST_W(8)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .burst_len(burst_len),
      .reseed(reseed), .seed_val(seed_val), .tx(tx), .busy(busy),
      .byte_out(byte_out), .byte_stb(byte_stb), .sent_cnt(sent_cnt), .done(done)
   );

   always #5 clk = ~clk;

   int errors = 0, checks = 0;
   int cyc = 0, t0 = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: a run is a sequence of P-cycle byte periods, pos 0 = load cycle.
   bit         mv = 0, m_busy, m_stopq, m_done, m_stb;
   int         m_pos, m_cnt, m_burst;
   logic [7:0] m_byte, m_lfsr;

   function automatic logic [7:0] step(input logic [7:0] v);
      return (v >> 1) ^ (v[0] ? TP : 8'h00);
   endfunction

   function automatic logic frame_bit(input logic [7:0] b, input int k);
      if (k == 0) return 1'b0;
      if (k <= 8) return b[k-1];
      if (NB == 11 && k == 9) return ^b;
      return 1'b1;
   endfunction

   task automatic m_new_byte();
      m_pos  = 0;
      m_byte = m_lfsr;
      m_stb  = 1;
      m_lfsr = step(m_lfsr);
   endtask

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (rst) begin
         mv = 1; m_busy = 0; m_lfsr = SD; m_byte = 0; m_cnt = 0;
         m_stopq = 0; m_done = 0; m_stb = 0; m_pos = 0; m_burst = 0;
      end else if (mv) begin
         m_done = 0;
         m_stb  = 0;
         if (!m_busy) begin
            if (start) begin
               m_busy = 1; m_burst = burst_len; m_cnt = 0; m_stopq = 0;
               m_new_byte();
            end else if (reseed) begin
               m_lfsr = (seed_val == 0) ? SD : seed_val;
            end
         end else begin
            if (stop) m_stopq = 1;
            if (m_pos == 0) m_cnt = (m_cnt + 1) % 256;
            if (m_pos == P - 1) begin
               if (m_stopq || (m_burst != 0 && m_cnt == m_burst)) begin
                  m_busy = 0; m_done = 1; m_stopq = 0;
               end else begin
                  m_new_byte();
               end
            end else begin
               m_pos++;
            end
         end
      end
   end

   // Event log for the literal checks, relative to the cycle start was driven.
   int         stb_c[$];
   logic [7:0] stb_v[$];
   int         done_c[$];
   logic       tx_log[0:199];

   always @(negedge clk) begin
      int   rel;
      logic exp_tx;
      if (mv) begin
         exp_tx = (m_busy && m_pos != 0) ? frame_bit(m_byte, (m_pos - 1) / CD) : 1'b1;
         chk("tx", tx, exp_tx);
         chk("busy", busy, m_busy);
         chk("byte_stb", byte_stb, m_stb);
         chk("done", done, m_done);
         chk("byte_out", byte_out, m_byte);
         chk("sent_cnt", sent_cnt, m_cnt);
         rel = cyc - t0;
         if (byte_stb) begin stb_c.push_back(rel); stb_v.push_back(byte_out); end
         if (done) done_c.push_back(rel);
         if (rel >= 0 && rel < 200) tx_log[rel] = tx;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic begin_run(input logic [7:0] bl);
      stb_c.delete(); stb_v.delete(); done_c.delete();
      start = 1; burst_len = bl; t0 = cyc;
      tick();
      start = 0; reseed = 0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (m_busy && n < budget) begin tick(); n++; end
      chk("idle_timeout", busy, 1'b0);
      tick(); tick();
   endtask

   task automatic wait_stb(input int cnt, input int budget);
      int n = 0;
      while (stb_v.size() < cnt && n < budget) begin tick(); n++; end
      chk("stb_timeout", stb_v.size(), cnt);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int exp_tx;
      tick(); tick();
      rst = 0;
      @(negedge clk);
      chk("reset_tx", tx, 1'b1);
      chk("reset_busy", busy, 1'b0);
      chk("reset_byte_out", byte_out, 8'h00);
      chk("reset_sent_cnt", sent_cnt, 8'h00);
      tick();

      // Three-byte burst from the reset seed, with frame timing and line decode.
      begin_run(8'd3);
      wait_idle(600);
      chk("t1_nbytes", stb_v.size(), 3);
      if (stb_v.size() == 3) begin
         chk("t1_byte0", stb_v[0], 8'h01);
         chk("t1_byte1", stb_v[1], 8'hB8);
         chk("t1_byte2", stb_v[2], 8'h5C);
         chk("t1_stb0_cycle", stb_c[0], 1);
`ifdef LFSR_UART_PARITY_EN
         chk("t1_stb1_cycle", stb_c[1], 46);
         chk("t1_stb2_cycle", stb_c[2], 91);
`else
         chk("t1_stb1_cycle", stb_c[1], 42);
         chk("t1_stb2_cycle", stb_c[2], 83);
`endif
      end
      chk("t1_ndone", done_c.size(), 1);
`ifdef LFSR_UART_PARITY_EN
      if (done_c.size() == 1) chk("t1_done_cycle", done_c[0], 136);
      chk("t6_parity_b8", tx_log[83], 1'b0);
`else
      if (done_c.size() == 1) chk("t1_done_cycle", done_c[0], 124);
`endif
      chk("t1_sent_cnt", sent_cnt, 8'd3);
      for (int k = 0; k < 42; k++) begin
         exp_tx = (k >= 2 && k <= 5) ? 0 : (k >= 6 && k <= 9) ? 1 : (k >= 10 && k <= 37) ? 0 : 1;
         chk($sformatf("t2_tx_cycle%0d", k), tx_log[k], exp_tx);
      end

      // Reseed with a value, with zero, and start+reseed together.
      reseed = 1; seed_val = 8'h2E; tick(); reseed = 0;
      begin_run(8'd1); wait_idle(200);
      if (stb_v.size() > 0) chk("t3_reseed_2e", stb_v[0], 8'h2E);
      reseed = 1; seed_val = 8'h00; tick(); reseed = 0;
      begin_run(8'd1); wait_idle(200);
      if (stb_v.size() > 0) chk("t3_reseed_zero", stb_v[0], 8'h01);
      reseed = 1; seed_val = 8'h77;
      begin_run(8'd1); wait_idle(200);
      if (stb_v.size() > 0) chk("t3_start_wins", stb_v[0], 8'hB8);

      // Continuous run stopped during byte 5's data bits; start mid-run ignored.
      begin_run(8'd0);
      wait_stb(5, 10 * P);
      repeat (15) tick();
      stop = 1; start = 1; tick(); stop = 0; start = 0;
      wait_idle(3 * P);
      chk("t4_nbytes", stb_v.size(), 5);
      chk("t4_sent_cnt", sent_cnt, 8'd5);
      chk("t4_ndone", done_c.size(), 1);

      // Stop in idle is ignored.
      stop = 1; tick(); stop = 0;
      begin_run(8'd1); wait_idle(200);
      chk("t4_idle_stop_ignored", stb_v.size(), 1);

      // Reset mid-data aborts without done, then the sequence restarts from SEED.
      begin_run(8'd3);
      wait_stb(1, 50);
      repeat (20) tick();
      rst = 1; tick(); rst = 0;
      @(negedge clk);
      chk("t5_tx", tx, 1'b1);
      chk("t5_busy", busy, 1'b0);
      chk("t5_sent_cnt", sent_cnt, 8'd0);
      repeat (5) tick();
      chk("t5_no_done", done_c.size(), 0);
      begin_run(8'd2); wait_idle(400);
      chk("t5_nbytes", stb_v.size(), 2);
      if (stb_v.size() == 2) begin
         chk("t5_byte0", stb_v[0], 8'h01);
         chk("t5_byte1", stb_v[1], 8'hB8);
      end

      // Randomised runs with junk start/reseed/burst_len and stray stops while busy.
      for (int r = 0; r < 8; r++) begin
         int n;
         logic [7:0] bl;
         reseed = ($urandom_range(0, 1) == 1);
         seed_val = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
         tick(); reseed = 0;
         bl = 8'($urandom_range(0, 3));
         begin_run(bl);
         n = 0;
         while (n < 6 * P) begin
            start = 0; reseed = 0; stop = 0;
            if (!m_busy) break;
            start     = ($urandom_range(0, 7) == 0);
            reseed    = ($urandom_range(0, 7) == 0);
            seed_val  = 8'($urandom);
            burst_len = 8'($urandom);
            stop      = ($urandom_range(0, 79) == 0) || (bl == 0 && n > 3 * P);
            tick();
            n++;
         end
         start = 0; reseed = 0; stop = 0;
         wait_idle(6 * P);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
